// File: rtl/ttt_pkg.sv
// ----------------------------------------------------------------------------
// ttt_pkg
//   Shared types and constants for the tictactoe input-conditioning stage.
//   - db_state_e : debouncer state encoding, also exported for observation.
//   - TTT_NSQ    : number of squares on the board (width of sel_pos).
//   - pos_onehot : binary square index -> one-hot square select, zero when
//                  the index does not name a square.
// ----------------------------------------------------------------------------
package ttt_pkg;

    localparam int TTT_NSQ = 9;

    typedef enum logic [1:0] {
        DB_IDLE    = 2'd0,
        DB_PRESS   = 2'd1,
        DB_HELD    = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_e;

    // Indices 0..8 select one square; 9..15 select nothing.
    function automatic logic [TTT_NSQ-1:0] pos_onehot(input logic [3:0] idx);
        logic [TTT_NSQ-1:0] r;
        r = '0;
        if (idx < 4'd9) begin
            r = TTT_NSQ'(1) << idx;
        end
        return r;
    endfunction

endpackage : ttt_pkg

// File: rtl/ttt_input_cond_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
//   Debounces one asynchronous, bouncy, active-high push button and produces
//   a single registered pulse per accepted press.
//
//   Ports
//     clk        in   system clock (posedge)
//     reset      in   synchronous, active-high
//     raw_btn_i  in   raw asynchronous button level
//     fire_o     out  one-cycle pulse, high in the cycle after entry to HELD
//     state_o    out  current debouncer state (observation / position latch)
//
//   A press is accepted after DB_CYCLES consecutive synchronised-high cycles
//   in PRESS. A release must likewise be stable for DB_CYCLES cycles in
//   RELEASE before the FSM returns to IDLE; a bounce back to high during
//   RELEASE goes straight back to HELD without firing, so a held or
//   chattering button can never produce a second pulse.
// ----------------------------------------------------------------------------
module btn_debounce
    import ttt_pkg::*;
#(
    parameter int DB_CYCLES = 250000,
    parameter int DB_W      = 18
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      raw_btn_i,
    output logic      fire_o,
    output db_state_e state_o
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

    // Two-flop synchroniser for the asynchronous button level.
    logic sync1_q;
    logic s_btn_q;

    db_state_e       state_q, state_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            fire_q, fire_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            s_btn_q <= 1'b0;
        end else begin
            sync1_q <= raw_btn_i;
            s_btn_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fire_q  <= fire_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_d  = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (s_btn_q) begin
                    state_d = DB_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (!s_btn_q) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Only the PRESS->HELD transition fires.
                    state_d = DB_HELD;
                    cnt_d   = '0;
                    fire_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DB_HELD: begin
                if (!s_btn_q) begin
                    state_d = DB_RELEASE;
                    cnt_d   = '0;
                end
            end
            DB_RELEASE: begin
                if (s_btn_q) begin
                    state_d = DB_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign fire_o  = fire_q;
    assign state_o = state_q;

endmodule : btn_debounce

// File: rtl/ttt_input_cond.sv
// ----------------------------------------------------------------------------
// ttt_input_cond
//   Input-conditioning stage in front of the tictactoe core.
//
//   Ports
//     clk        in   1  system clock, all logic on posedge
//     reset      in   1  synchronous, active-high
//     raw_btn_x  in   1  raw X button (asynchronous, bouncy)
//     raw_btn_o  in   1  raw O button (asynchronous, bouncy)
//     pos_sw     in   4  binary square index 0..8 (asynchronous)
//     buttonX    out  1  one-cycle accepted X press
//     buttonO    out  1  one-cycle accepted O press
//     sel_pos    out  9  one-hot selected square, 0 when pos_sw > 8
//     pos_err    out  1  latched pos_sw value is > 8
//     flash_clk  out  1  50% square wave, period 2*FLASH_HALF cycles
//
//   Handshake: there is none. buttonX/buttonO are single-cycle strobes with
//   no back-pressure; sel_pos/pos_err are level outputs that the core samples
//   when it sees a strobe and that stay frozen while any button is active.
//
//   All outputs come straight from flops.
// ----------------------------------------------------------------------------
module ttt_input_cond
    import ttt_pkg::*;
#(
    parameter int DB_CYCLES  = 250000,
    parameter int DB_W       = 18,
    parameter int FLASH_HALF = 12500000,
    parameter int FL_W       = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               raw_btn_x,
    input  logic               raw_btn_o,
    input  logic [3:0]         pos_sw,
    output logic               buttonX,
    output logic               buttonO,
    output logic [TTT_NSQ-1:0] sel_pos,
    output logic               pos_err,
    output logic               flash_clk
);

    localparam logic [FL_W-1:0] FCNT_LAST = FL_W'(FLASH_HALF - 1);
    localparam logic [FL_W-1:0] FCNT_ONE  = FL_W'(1);

    // ------------------------------------------------------------------
    // Button debouncers
    // ------------------------------------------------------------------
    logic      fire_x, fire_o;
    db_state_e st_x, st_o;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_x (
        .clk       (clk),
        .reset     (reset),
        .raw_btn_i (raw_btn_x),
        .fire_o    (fire_x),
        .state_o   (st_x)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_db_o (
        .clk       (clk),
        .reset     (reset),
        .raw_btn_i (raw_btn_o),
        .fire_o    (fire_o),
        .state_o   (st_o)
    );

    // ------------------------------------------------------------------
    // Pulse arbitration: a simultaneous X and O acceptance is ambiguous,
    // so neither move is reported. Both debouncers still sit in HELD and
    // need a clean release before either can fire again.
    // ------------------------------------------------------------------
    logic button_x_q, button_x_d;
    logic button_o_q, button_o_d;

    always_comb begin
        button_x_d = fire_x & ~fire_o;
        button_o_d = fire_o & ~fire_x;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            button_x_q <= 1'b0;
            button_o_q <= 1'b0;
        end else begin
            button_x_q <= button_x_d;
            button_o_q <= button_o_d;
        end
    end

    // ------------------------------------------------------------------
    // Position switch synchroniser and latch
    // ------------------------------------------------------------------
    logic [3:0] pos_sync1_q;
    logic [3:0] s_pos_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_sync1_q <= '0;
            s_pos_q     <= '0;
        end else begin
            pos_sync1_q <= pos_sw;
            s_pos_q     <= pos_sync1_q;
        end
    end

    // Tracking only while both buttons are idle keeps sel_pos constant from
    // the first sign of a press until the button is fully released, so the
    // core checks and commits the same square it was given with the pulse.
    logic               both_idle;
    logic [TTT_NSQ-1:0] sel_pos_q, sel_pos_d;
    logic               pos_err_q, pos_err_d;

    always_comb begin
        both_idle = (st_x == DB_IDLE) && (st_o == DB_IDLE);
        sel_pos_d = sel_pos_q;
        pos_err_d = pos_err_q;
        if (both_idle) begin
            sel_pos_d = pos_onehot(s_pos_q);
            pos_err_d = (s_pos_q > 4'd8);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_pos_q <= '0;
            pos_err_q <= 1'b0;
        end else begin
            sel_pos_q <= sel_pos_d;
            pos_err_q <= pos_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Flash divider: toggles every FLASH_HALF cycles, first rise FLASH_HALF
    // cycles after reset is released.
    // ------------------------------------------------------------------
    logic [FL_W-1:0] fcnt_q, fcnt_d;
    logic            flash_q, flash_d;

    always_comb begin
        fcnt_d  = fcnt_q + FCNT_ONE;
        flash_d = flash_q;
        if (fcnt_q == FCNT_LAST) begin
            fcnt_d  = '0;
            flash_d = ~flash_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt_q  <= '0;
            flash_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            flash_q <= flash_d;
        end
    end

    assign buttonX   = button_x_q;
    assign buttonO   = button_o_q;
    assign sel_pos   = sel_pos_q;
    assign pos_err   = pos_err_q;
    assign flash_clk = flash_q;

endmodule : ttt_input_cond

// File: tb/tb_ttt_input_cond.sv
// ----------------------------------------------------------------------------
// tb_ttt_input_cond
//   Directed bench for ttt_input_cond with DB_CYCLES=4, FLASH_HALF=3.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point. In every pulse window, index i=0 is the first rising edge that
//   samples the new raw level, so an accepted press shows up at i == 7.
// ----------------------------------------------------------------------------
module tb_ttt_input_cond;

    localparam int DB_CYCLES  = 4;
    localparam int DB_W       = 3;
    localparam int FLASH_HALF = 3;
    localparam int FL_W       = 2;
    localparam int LAT        = 7;

    logic       clk;
    logic       reset;
    logic       raw_btn_x;
    logic       raw_btn_o;
    logic [3:0] pos_sw;
    logic       buttonX;
    logic       buttonO;
    logic [8:0] sel_pos;
    logic       pos_err;
    logic       flash_clk;

    int n_checks;
    int n_pass;

    ttt_input_cond #(
        .DB_CYCLES  (DB_CYCLES),
        .DB_W       (DB_W),
        .FLASH_HALF (FLASH_HALF),
        .FL_W       (FL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_btn_x (raw_btn_x),
        .raw_btn_o (raw_btn_o),
        .pos_sw    (pos_sw),
        .buttonX   (buttonX),
        .buttonO   (buttonO),
        .sel_pos   (sel_pos),
        .pos_err   (pos_err),
        .flash_clk (flash_clk)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        raw_btn_x = 1'b0;
        raw_btn_o = 1'b0;
        pos_sw    = 4'd0;
        idle(3);
        n_checks++;
        if (buttonX !== 1'b0) $display("FAIL reset_buttonX got %b want 0", buttonX); else n_pass++;
        n_checks++;
        if (buttonO !== 1'b0) $display("FAIL reset_buttonO got %b want 0", buttonO); else n_pass++;
        n_checks++;
        if (sel_pos !== 9'd0) $display("FAIL reset_sel_pos got %b want 0", sel_pos); else n_pass++;
        n_checks++;
        if (pos_err !== 1'b0) $display("FAIL reset_pos_err got %b want 0", pos_err); else n_pass++;
        n_checks++;
        if (flash_clk !== 1'b0) $display("FAIL reset_flash got %b want 0", flash_clk); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_clean_x();
        pos_sw = 4'd4;
        idle(5);
        raw_btn_x = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (buttonX !== (i == LAT))
                $display("FAIL clean_x_pulse i=%0d got %b want %b", i, buttonX, (i == LAT));
            else n_pass++;
            n_checks++;
            if (buttonO !== 1'b0) $display("FAIL clean_x_no_o i=%0d got %b want 0", i, buttonO); else n_pass++;
            if (i == LAT) begin
                n_checks++;
                if (sel_pos !== 9'b000010000)
                    $display("FAIL clean_x_sel_pos got %b want 000010000", sel_pos);
                else n_pass++;
            end
        end
        raw_btn_x = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (buttonX !== 1'b0) $display("FAIL clean_x_release i=%0d got %b want 0", i, buttonX); else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int j = 0; j < 5; j++) begin
            raw_btn_x = pat[j];
            tick();
            n_checks++;
            if (buttonX !== 1'b0) $display("FAIL bounce_early j=%0d got %b want 0", j, buttonX); else n_pass++;
        end
        // Last pattern entry is the final rising edge (i=0); pulse at i=7.
        for (int i = 1; i <= 14; i++) begin
            tick();
            n_checks++;
            if (buttonX !== (i == LAT))
                $display("FAIL bounce_pulse i=%0d got %b want %b", i, buttonX, (i == LAT));
            else n_pass++;
        end
        raw_btn_x = 1'b0;
        idle(10);
    endtask

    task automatic test_simultaneous();
        raw_btn_x = 1'b1;
        raw_btn_o = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if ({buttonX, buttonO} !== 2'b00)
                $display("FAIL simul_suppress i=%0d got %b%b want 00", i, buttonX, buttonO);
            else n_pass++;
        end
        raw_btn_x = 1'b0;
        raw_btn_o = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({buttonX, buttonO} !== 2'b00)
                $display("FAIL simul_release i=%0d got %b%b want 00", i, buttonX, buttonO);
            else n_pass++;
        end
        raw_btn_o = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (buttonO !== (i == LAT))
                $display("FAIL simul_o_alone i=%0d got %b want %b", i, buttonO, (i == LAT));
            else n_pass++;
            n_checks++;
            if (buttonX !== 1'b0) $display("FAIL simul_o_no_x i=%0d got %b want 0", i, buttonX); else n_pass++;
        end
        raw_btn_o = 1'b0;
        idle(10);
    endtask

    task automatic test_pos_freeze();
        logic [8:0] exp_sel;
        pos_sw = 4'd2;
        idle(5);
        n_checks++;
        if (sel_pos !== 9'b000000100) $display("FAIL freeze_pre got %b want 000000100", sel_pos); else n_pass++;
        raw_btn_x = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (buttonX !== (i == LAT))
                $display("FAIL freeze_pulse i=%0d got %b want %b", i, buttonX, (i == LAT));
            else n_pass++;
        end
        pos_sw = 4'd7;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (sel_pos !== 9'b000000100)
                $display("FAIL freeze_held i=%0d got %b want 000000100", i, sel_pos);
            else n_pass++;
        end
        // Release sampled at i=0; RELEASE->IDLE at i=6; reload at i=7.
        raw_btn_x = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            exp_sel = (i >= 7) ? 9'b010000000 : 9'b000000100;
            n_checks++;
            if (sel_pos !== exp_sel)
                $display("FAIL freeze_release i=%0d got %b want %b", i, sel_pos, exp_sel);
            else n_pass++;
        end
        n_checks++;
        if (pos_err !== 1'b0) $display("FAIL freeze_pos_err got %b want 0", pos_err); else n_pass++;
    endtask

    task automatic test_out_of_range();
        pos_sw = 4'd12;
        idle(5);
        n_checks++;
        if (sel_pos !== 9'd0) $display("FAIL oor_sel_pos got %b want 0", sel_pos); else n_pass++;
        n_checks++;
        if (pos_err !== 1'b1) $display("FAIL oor_pos_err got %b want 1", pos_err); else n_pass++;
        raw_btn_o = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (buttonO !== (i == LAT))
                $display("FAIL oor_pulse i=%0d got %b want %b", i, buttonO, (i == LAT));
            else n_pass++;
            if (i == LAT) begin
                n_checks++;
                if ({sel_pos, pos_err} !== {9'd0, 1'b1})
                    $display("FAIL oor_at_pulse got %b/%b want 000000000/1", sel_pos, pos_err);
                else n_pass++;
            end
        end
        raw_btn_o = 1'b0;
        pos_sw    = 4'd0;
        idle(12);
        n_checks++;
        if ({sel_pos, pos_err} !== {9'b000000001, 1'b0})
            $display("FAIL oor_recover got %b/%b want 000000001/0", sel_pos, pos_err);
        else n_pass++;
    endtask

    task automatic test_flash_reset();
        logic exp_f;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_f = ((n / FLASH_HALF) % 2) == 1;
            n_checks++;
            if (flash_clk !== exp_f)
                $display("FAIL flash n=%0d got %b want %b", n, flash_clk, exp_f);
            else n_pass++;
        end
        // Get X into PRESS, then reset it mid-count.
        raw_btn_x = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (buttonX !== 1'b0) $display("FAIL rst_pre i=%0d got %b want 0", i, buttonX); else n_pass++;
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({buttonX, buttonO, sel_pos, pos_err, flash_clk} !== 13'd0)
            $display("FAIL rst_mid_press got %b%b %b %b %b want all 0",
                     buttonX, buttonO, sel_pos, pos_err, flash_clk);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            n_checks++;
            if (buttonX !== (i == LAT))
                $display("FAIL rst_refire i=%0d got %b want %b", i, buttonX, (i == LAT));
            else n_pass++;
        end
        raw_btn_x = 1'b0;
        idle(4);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        raw_btn_x = 1'b0;
        raw_btn_o = 1'b0;
        pos_sw    = 4'd0;
        test_reset();
        test_clean_x();
        test_bounce();
        test_simultaneous();
        test_pos_freeze();
        test_out_of_range();
        test_flash_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ttt_input_cond
